// File: rtl/comp_pkg.sv
// Shared types and constants for the comp equality comparator and its sequencer.
package comp_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  // Sub-phase within SCAN when settling is enabled
  typedef enum logic {
    DRIVE  = 1'b0,
    SAMPLE = 1'b1
  } phase_t;

  // A full wrap-around scan covers 2^w candidates, so the count needs one extra bit
  function automatic int cnt_w(input int w);
    return w + 1;
  endfunction
endpackage

// File: rtl/comp.sv
// Combinational equality comparator: equal_o = (a_i == b_i).
module comp
  import comp_pkg::*;
#(
  parameter int width = WIDTH_DEF
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             equal_o
);
  assign equal_o = (a_i == b_i);
endmodule

// File: rtl/comp_seq.sv
// Sequential search initiator for the external comp block: scans [start, stop] with wrap.
// Build option COMP_SEQ_SETTLE_EN: two cycles per candidate (DRIVE then SAMPLE).
module comp_seq
  import comp_pkg::*;
#(
  parameter int width = WIDTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [width-1:0]          target_i,
  input  logic [width-1:0]          start_i,
  input  logic [width-1:0]          stop_i,
  output logic [width-1:0]          cmp_a_o,
  output logic [width-1:0]          cmp_b_o,
  input  logic                      cmp_equal_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic                      rsp_found_o,
  output logic [width-1:0]          rsp_index_o,
  output logic [cnt_w(width)-1:0]   rsp_count_o
);
  state_t           state;
  logic [width-1:0] stop_q;
  logic             sample_en;

`ifdef COMP_SEQ_SETTLE_EN
  phase_t phase;
  assign sample_en = (phase == SAMPLE);
`else
  assign sample_en = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      cmp_a_o     <= '0;
      cmp_b_o     <= '0;
      stop_q      <= '0;
      rsp_found_o <= 1'b0;
      rsp_index_o <= '0;
      rsp_count_o <= '0;
`ifdef COMP_SEQ_SETTLE_EN
      phase       <= DRIVE;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          cmp_a_o     <= start_i;
          cmp_b_o     <= target_i;
          stop_q      <= stop_i;
          rsp_count_o <= {{(cnt_w(width)-1){1'b0}}, 1'b1};
          req_ready_o <= 1'b0;
          state       <= SCAN;
`ifdef COMP_SEQ_SETTLE_EN
          phase       <= DRIVE;
`endif
        end
        SCAN: begin
`ifdef COMP_SEQ_SETTLE_EN
          phase <= (phase == DRIVE) ? SAMPLE : DRIVE;
`endif
          if (sample_en) begin
            // A match on the last candidate still reports found
            if (cmp_equal_i) begin
              rsp_found_o <= 1'b1;
              rsp_index_o <= cmp_a_o;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else if (cmp_a_o == stop_q) begin
              rsp_found_o <= 1'b0;
              rsp_index_o <= stop_q;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else begin
              cmp_a_o     <= cmp_a_o + 1'b1;
              rsp_count_o <= rsp_count_o + 1'b1;
            end
          end
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
